pipeline_regfetch_fwd: RTL and testbench

//  Register-fetch (ID) stage: decodes rs/rt, reads the regfile, forwards from EX/MEM, registers operands for EX.

---
 rtl/pipeline_regfetch_fwd_pkg.sv | 16 +
 rtl/pipeline_fwd_mux.sv | 44 ++++
 rtl/pipeline_regfetch_fwd.sv | 117 +++++++++++
 tb/tb_pipeline_regfetch_fwd.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_regfetch_fwd_pkg.sv
// Shared definitions for the register-fetch stage: instruction field
// positions and the operand-source encoding used by the bypass muxes.
package pipeline_regfetch_fwd_pkg;

  // Low bit of each source-register field; the width comes from REG_AW.
  localparam int RS_LO = 21;
  localparam int RT_LO = 16;

  typedef enum logic [1:0] {
    SRC_RF   = 2'd0,
    SRC_ZERO = 2'd1,
    SRC_EX   = 2'd2,
    SRC_MEM  = 2'd3
  } src_sel_e;

endpackage

// File: rtl/pipeline_fwd_mux.sv
// Operand bypass for one source register.
// EX beats MEM beats the regfile; a load still in EX is never a source.
module pipeline_fwd_mux
  import pipeline_regfetch_fwd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic [REG_AW-1:0]     idx,
  input  logic [DATA_WIDTH-1:0] rout,
  input  logic                  ex_wr_en,
  input  logic [REG_AW-1:0]     ex_wr_idx,
  input  logic [DATA_WIDTH-1:0] ex_wr_val,
  input  logic                  ex_is_load,
  input  logic                  mem_wr_en,
  input  logic [REG_AW-1:0]     mem_wr_idx,
  input  logic [DATA_WIDTH-1:0] mem_wr_val,
  output logic [DATA_WIDTH-1:0] operand
);

  src_sel_e sel;

  always_comb begin
    sel = SRC_RF;
    if (ZERO_REG != 0 && idx == '0)
      sel = SRC_ZERO;
    else if (ex_wr_en && !ex_is_load && ex_wr_idx == idx)
      sel = SRC_EX;
    else if (mem_wr_en && mem_wr_idx == idx)
      sel = SRC_MEM;
  end

  always_comb begin
    operand = rout;
    case (sel)
      SRC_ZERO: operand = '0;
      SRC_EX:   operand = ex_wr_val;
      SRC_MEM:  operand = mem_wr_val;
      default:  operand = rout;
    endcase
  end

endmodule

// File: rtl/pipeline_regfetch_fwd.sv
// Register-fetch (ID) stage: reads and bypasses rs/rt, registers them for EX,
// inserts a single bubble on a load-use hazard and counts those bubbles.
module pipeline_regfetch_fwd
  import pipeline_regfetch_fwd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5,
  parameter int ZERO_REG   = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           inst_in,
  input  logic                  inst_valid,
  output logic [REG_AW-1:0]     rindex0,
  input  logic [DATA_WIDTH-1:0] rout0,
  output logic [REG_AW-1:0]     rindex1,
  input  logic [DATA_WIDTH-1:0] rout1,
  input  logic                  ex_wr_en,
  input  logic [REG_AW-1:0]     ex_wr_idx,
  input  logic [DATA_WIDTH-1:0] ex_wr_val,
  input  logic                  ex_is_load,
  input  logic                  mem_wr_en,
  input  logic [REG_AW-1:0]     mem_wr_idx,
  input  logic [DATA_WIDTH-1:0] mem_wr_val,
  input  logic                  stall_in,
  input  logic                  flush,
  output logic                  stall_out,
  output logic                  valid_out,
  output logic [31:0]           inst_out,
  output logic [DATA_WIDTH-1:0] rs_val,
  output logic [DATA_WIDTH-1:0] rt_val,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  // Handshake: valid_out qualifies inst_out/rs_val/rt_val. stall_in is EX's
  // not-ready: while high every output register holds. stall_out is this
  // stage's not-ready towards fetch, which must then hold inst_in.

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [REG_AW-1:0]     rs_idx;
  logic [REG_AW-1:0]     rt_idx;
  logic [DATA_WIDTH-1:0] rs_fwd;
  logic [DATA_WIDTH-1:0] rt_fwd;
  logic                  ex_idx_live;
  logic                  hazard;

  assign rs_idx  = inst_in[RS_LO +: REG_AW];
  assign rt_idx  = inst_in[RT_LO +: REG_AW];
  assign rindex0 = rs_idx;
  assign rindex1 = rt_idx;

  pipeline_fwd_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_AW     (REG_AW),
    .ZERO_REG   (ZERO_REG)
  ) u_rs_mux (
    .idx        (rs_idx),
    .rout       (rout0),
    .ex_wr_en   (ex_wr_en),
    .ex_wr_idx  (ex_wr_idx),
    .ex_wr_val  (ex_wr_val),
    .ex_is_load (ex_is_load),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_idx (mem_wr_idx),
    .mem_wr_val (mem_wr_val),
    .operand    (rs_fwd)
  );

  pipeline_fwd_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_AW     (REG_AW),
    .ZERO_REG   (ZERO_REG)
  ) u_rt_mux (
    .idx        (rt_idx),
    .rout       (rout1),
    .ex_wr_en   (ex_wr_en),
    .ex_wr_idx  (ex_wr_idx),
    .ex_wr_val  (ex_wr_val),
    .ex_is_load (ex_is_load),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_idx (mem_wr_idx),
    .mem_wr_val (mem_wr_val),
    .operand    (rt_fwd)
  );

  // rt is always compared, so I-type instructions may bubble spuriously.
  assign ex_idx_live = (ZERO_REG == 0) || (ex_wr_idx != '0);
  assign hazard = inst_valid && ex_wr_en && ex_is_load && ex_idx_live &&
                  (ex_wr_idx == rs_idx || ex_wr_idx == rt_idx);
  assign stall_out = !rst && !flush && (hazard || stall_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out   <= 1'b0;
      inst_out    <= '0;
      rs_val      <= '0;
      rt_val      <= '0;
      stall_count <= '0;
    end else if (flush) begin
      valid_out <= 1'b0;
    end else if (stall_in) begin
      valid_out <= valid_out;
    end else if (hazard) begin
      valid_out <= 1'b0;
      if (!(&stall_count))
        stall_count <= stall_count + CNT_ONE;
    end else begin
      valid_out <= inst_valid;
      inst_out  <= inst_in;
      rs_val    <= rs_fwd;
      rt_val    <= rt_fwd;
    end
  end

endmodule

// File: tb/tb_pipeline_regfetch_fwd.sv
// Bench for pipeline_regfetch_fwd: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_pipeline_regfetch_fwd;

  localparam int CW = 4;
  localparam int W  = 1 + 32 + 32 + 32 + CW;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic        clk;
  logic        rst;
  logic [31:0] inst_in;
  logic        inst_valid;
  logic [4:0]  rindex0;
  logic [31:0] rout0;
  logic [4:0]  rindex1;
  logic [31:0] rout1;
  logic        ex_wr_en;
  logic [4:0]  ex_wr_idx;
  logic [31:0] ex_wr_val;
  logic        ex_is_load;
  logic        mem_wr_en;
  logic [4:0]  mem_wr_idx;
  logic [31:0] mem_wr_val;
  logic        stall_in;
  logic        flush;
  logic        stall_out;
  logic        valid_out;
  logic [31:0] inst_out;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [CW-1:0] stall_count;

  pipeline_regfetch_fwd #(
    .DATA_WIDTH (32),
    .REG_AW     (5),
    .ZERO_REG   (1),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_in     (inst_in),
    .inst_valid  (inst_valid),
    .rindex0     (rindex0),
    .rout0       (rout0),
    .rindex1     (rindex1),
    .rout1       (rout1),
    .ex_wr_en    (ex_wr_en),
    .ex_wr_idx   (ex_wr_idx),
    .ex_wr_val   (ex_wr_val),
    .ex_is_load  (ex_is_load),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_idx  (mem_wr_idx),
    .mem_wr_val  (mem_wr_val),
    .stall_in    (stall_in),
    .flush       (flush),
    .stall_out   (stall_out),
    .valid_out   (valid_out),
    .inst_out    (inst_out),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .stall_count (stall_count)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state: what EX should be seeing after the next edge
  logic          m_valid;
  logic [31:0]   m_inst;
  logic [31:0]   m_rs;
  logic [31:0]   m_rt;
  int            m_cnt;
  logic [W-1:0]  exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    mk_inst = {6'h08, rs, rt, imm};
  endfunction

  // Value a source register should read given what is in flight downstream.
  function automatic logic [31:0] ref_operand(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0) return 32'd0;
    if (ex_wr_en && !ex_is_load && ex_wr_idx == idx) return ex_wr_val;
    if (mem_wr_en && mem_wr_idx == idx) return mem_wr_val;
    return rf;
  endfunction

  task automatic idle_inputs();
    inst_in = 32'd0; inst_valid = 1'b0;
    rout0 = 32'd0; rout1 = 32'd0;
    ex_wr_en = 1'b0; ex_wr_idx = 5'd0; ex_wr_val = 32'd0; ex_is_load = 1'b0;
    mem_wr_en = 1'b0; mem_wr_idx = 5'd0; mem_wr_val = 32'd0;
    stall_in = 1'b0; flush = 1'b0;
  endtask

  // One clock: check combinational outputs, predict, clock, compare.
  task automatic cycle(input string tag);
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic         hz;
    logic [W-1:0] exp;
    logic [W-1:0] got;
    #1;
    rs = inst_in[25:21];
    rt = inst_in[20:16];
    hz = inst_valid && ex_wr_en && ex_is_load && ex_wr_idx != 0 &&
         (ex_wr_idx == rs || ex_wr_idx == rt);
    chk({tag, ".stall_out"}, 128'(stall_out), 128'(!rst && !flush && (hz || stall_in)));
    chk({tag, ".rindex"}, 128'({rindex0, rindex1}), 128'({rs, rt}));
    if (rst) begin
      m_valid = 1'b0; m_inst = 32'd0; m_rs = 32'd0; m_rt = 32'd0; m_cnt = 0;
    end else if (flush) begin
      m_valid = 1'b0;
    end else if (stall_in) begin
      m_valid = m_valid;
    end else if (hz) begin
      m_valid = 1'b0;
      if (m_cnt < CNT_MAX) m_cnt++;
    end else begin
      m_valid = inst_valid;
      m_inst  = inst_in;
      m_rs    = ref_operand(rs, rout0);
      m_rt    = ref_operand(rt, rout1);
    end
    exp_q.push_back({m_valid, m_inst, m_rs, m_rt, CW'(m_cnt)});
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    got = {valid_out, inst_out, rs_val, rt_val, stall_count};
    chk({tag, ".regs"}, 128'(got), 128'(exp));
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cycle("reset");
    rst = 1'b0;
  endtask

  typedef struct {
    logic        iv;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] r0;
    logic [31:0] r1;
    logic        ex_en;
    logic [4:0]  ex_idx;
    logic [31:0] ex_val;
    logic        ex_ld;
    logic        mem_en;
    logic [4:0]  mem_idx;
    logic [31:0] mem_val;
    logic        fl;
    logic        e_stall;
    logic        e_valid;
    logic        chk_ops;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] held_inst;
    rst = 1'b1;
    idle_inputs();
    m_valid = 1'b0; m_inst = 32'd0; m_rs = 32'd0; m_rt = 32'd0; m_cnt = 0;

    vecs[0] = '{1, 5'd1, 5'd2, 32'd5,  32'd7,  0, 5'd0, 32'h0,  0, 0, 5'd0, 32'h0,  0, 0, 1, 1, 32'd5,  32'd7};
    vecs[1] = '{1, 5'd3, 5'd2, 32'd1,  32'd7,  1, 5'd3, 32'hAA, 0, 1, 5'd3, 32'hBB, 0, 0, 1, 1, 32'hAA, 32'd7};
    vecs[2] = '{1, 5'd6, 5'd6, 32'd1,  32'd2,  1, 5'd9, 32'hCC, 0, 1, 5'd6, 32'hBB, 0, 0, 1, 1, 32'hBB, 32'hBB};
    vecs[3] = '{1, 5'd0, 5'd5, 32'h11, 32'h22, 1, 5'd0, 32'hFF, 0, 0, 5'd0, 32'h0,  0, 0, 1, 1, 32'd0,  32'h22};
    vecs[4] = '{1, 5'd1, 5'd2, 32'h66, 32'h77, 1, 5'd7, 32'h99, 1, 1, 5'd2, 32'h44, 0, 0, 1, 1, 32'h66, 32'h44};
    vecs[5] = '{1, 5'd0, 5'd3, 32'h12, 32'h33, 1, 5'd0, 32'h99, 1, 0, 5'd0, 32'h0,  0, 0, 1, 1, 32'd0,  32'h33};
    vecs[6] = '{0, 5'd4, 5'd1, 32'h55, 32'h56, 1, 5'd4, 32'h77, 1, 0, 5'd0, 32'h0,  0, 0, 0, 1, 32'h55, 32'h56};
    vecs[7] = '{1, 5'd9, 5'd8, 32'h3,  32'h4,  1, 5'd8, 32'h1,  0, 1, 5'd8, 32'h2,  0, 0, 1, 1, 32'h3,  32'h1};
    vecs[8] = '{1, 5'd4, 5'd4, 32'h3,  32'h4,  1, 5'd4, 32'h1,  1, 0, 5'd0, 32'h0,  1, 0, 0, 0, 32'h0,  32'h0};

    // reset state
    cycle("rst0");
    chk("rst.valid_out", 128'(valid_out), 128'(0));
    chk("rst.stall_count", 128'(stall_count), 128'(0));
    rst = 1'b0;

    // directed vector table
    for (int i = 0; i < 9; i++) begin
      inst_in = mk_inst(vecs[i].rs, vecs[i].rt, 16'(i * 17));
      inst_valid = vecs[i].iv;
      rout0 = vecs[i].r0; rout1 = vecs[i].r1;
      ex_wr_en = vecs[i].ex_en; ex_wr_idx = vecs[i].ex_idx;
      ex_wr_val = vecs[i].ex_val; ex_is_load = vecs[i].ex_ld;
      mem_wr_en = vecs[i].mem_en; mem_wr_idx = vecs[i].mem_idx; mem_wr_val = vecs[i].mem_val;
      flush = vecs[i].fl; stall_in = 1'b0;
      #1;
      chk($sformatf("vec%0d.stall_out", i), 128'(stall_out), 128'(vecs[i].e_stall));
      cycle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.valid_out", i), 128'(valid_out), 128'(vecs[i].e_valid));
      if (vecs[i].chk_ops) begin
        chk($sformatf("vec%0d.rs_val", i), 128'(rs_val), 128'(vecs[i].e_rs));
        chk($sformatf("vec%0d.rt_val", i), 128'(rt_val), 128'(vecs[i].e_rt));
      end
    end

    // load-use: one bubble, then the held instruction picks up the MEM value
    do_reset();
    inst_in = mk_inst(5'd1, 5'd4, 16'h0042); inst_valid = 1'b1;
    rout0 = 32'h10; rout1 = 32'h0;
    ex_wr_en = 1'b1; ex_wr_idx = 5'd4; ex_is_load = 1'b1; ex_wr_val = 32'hDEAD;
    #1;
    chk("lu.stall_out", 128'(stall_out), 128'(1));
    cycle("lu0");
    chk("lu.bubble", 128'({valid_out, stall_count}), 128'({1'b0, CW'(1)}));
    ex_wr_en = 1'b0; ex_is_load = 1'b0;
    mem_wr_en = 1'b1; mem_wr_idx = 5'd4; mem_wr_val = 32'h1234;
    cycle("lu1");
    chk("lu.rt_val", 128'({valid_out, rs_val, rt_val}), 128'({1'b1, 32'h10, 32'h1234}));

    // stall_in holds outputs for 3 cycles while inputs change, then flush
    idle_inputs();
    inst_in = mk_inst(5'd5, 5'd6, 16'h0101); inst_valid = 1'b1;
    rout0 = 32'hA5; rout1 = 32'h5A;
    cycle("hold0");
    held_inst = inst_in;
    for (int k = 0; k < 3; k++) begin
      stall_in = 1'b1;
      inst_in = $urandom; inst_valid = 1'($urandom_range(0, 1));
      rout0 = $urandom; rout1 = $urandom;
      ex_wr_en = 1'b1; ex_is_load = 1'($urandom_range(0, 1));
      ex_wr_idx = inst_in[20:16]; ex_wr_val = $urandom;
      cycle($sformatf("hold%0d", k + 1));
      chk($sformatf("hold%0d.outs", k + 1), 128'({valid_out, inst_out, rs_val, rt_val, stall_count}),
          128'({1'b1, held_inst, 32'hA5, 32'h5A, CW'(1)}));
    end
    flush = 1'b1;
    #1;
    chk("flush.stall_out", 128'(stall_out), 128'(0));
    cycle("flush");
    chk("flush.valid_out", 128'(valid_out), 128'(0));

    // reset in the middle of a hazard
    idle_inputs();
    inst_in = mk_inst(5'd7, 5'd2, 16'h0); inst_valid = 1'b1;
    ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_idx = 5'd7;
    cycle("prehz");
    rst = 1'b1;
    #1;
    chk("rsthz.stall_out", 128'(stall_out), 128'(0));
    cycle("rsthz");
    chk("rsthz.outs", 128'({valid_out, inst_out, rs_val, rt_val, stall_count}), 128'(0));
    rst = 1'b0;

    // counter saturates at all-ones
    for (int k = 0; k < CNT_MAX + 5; k++) cycle("sat");
    chk("sat.stall_count", 128'(stall_count), 128'(CNT_MAX));

    // randomized run with small index range to force collisions
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) < 2);
      flush = ($urandom_range(0, 99) < 6);
      stall_in = ($urandom_range(0, 99) < 15);
      inst_valid = ($urandom_range(0, 99) < 85);
      inst_in = mk_inst(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
      rout0 = $urandom; rout1 = $urandom;
      ex_wr_en = 1'($urandom_range(0, 1)); ex_is_load = ($urandom_range(0, 99) < 30);
      ex_wr_idx = 5'($urandom_range(0, 7)); ex_wr_val = $urandom;
      mem_wr_en = 1'($urandom_range(0, 1));
      mem_wr_idx = 5'($urandom_range(0, 7)); mem_wr_val = $urandom;
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
